// File: rtl/accelerator_vector_integer_stream_driver.sv
// Initiator-side sequencer for the vector integer accelerators.
// The host loads operand buffers A and B, starts a run, and reads results back.
// Element pairs are streamed one per result over an enable-strobe interface.
module accelerator_vector_integer_stream_driver #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int ADDR_SIZE    = 4,
    parameter int TIMEOUT      = 1024
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    output logic                    ERROR,
    input  logic [CONTROL_SIZE-1:0] SIZE_IN,
    input  logic                    LOAD_ENABLE,
    input  logic                    LOAD_SELECT,
    input  logic [ADDR_SIZE-1:0]    LOAD_ADDRESS,
    input  logic [DATA_SIZE-1:0]    LOAD_DATA,
    input  logic [ADDR_SIZE-1:0]    RESULT_ADDRESS,
    output logic [DATA_SIZE-1:0]    RESULT_DATA,
    output logic                    VECTOR_START,
    input  logic                    VECTOR_READY,
    output logic [CONTROL_SIZE-1:0] SIZE_OUT,
    output logic                    DATA_A_OUT_ENABLE,
    output logic                    DATA_B_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    DATA_A_OUT,
    output logic [DATA_SIZE-1:0]    DATA_B_OUT,
    input  logic                    DATA_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    DATA_IN
);

    localparam int DEPTH  = 2 ** ADDR_SIZE;
    localparam int WDOG_W = $clog2(TIMEOUT + 1);
    localparam logic [CONTROL_SIZE-1:0] DEPTH_C     = CONTROL_SIZE'(DEPTH);
    localparam logic [WDOG_W-1:0]       WDOG_LAST_C = WDOG_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_SEND   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                  state_r, state_nx_s;
    logic [ADDR_SIZE-1:0]    index_r, index_nx_s;
    logic [CONTROL_SIZE-1:0] size_r, size_nx_s;
    logic [WDOG_W-1:0]       wdog_r, wdog_nx_s, wdog_inc_s;
    logic                    ready_r, ready_nx_s;
    logic                    error_r, error_nx_s;
    logic                    vstart_r, vstart_nx_s;
    logic                    strobe_r, strobe_nx_s;
    logic [CONTROL_SIZE-1:0] size_out_r;
    logic [DATA_SIZE-1:0]    a_out_r, b_out_r, result_data_r;
    logic                    res_we_s, load_we_s, size_ok_s, last_s, wdog_expired_s;

    // Buffers are plain storage with no reset; contents are undefined after reset.
    logic [DATA_SIZE-1:0]    buf_a_r   [DEPTH];
    logic [DATA_SIZE-1:0]    buf_b_r   [DEPTH];
    logic [DATA_SIZE-1:0]    res_buf_r [DEPTH];

    assign size_ok_s      = (SIZE_IN != {CONTROL_SIZE{1'b0}}) && (SIZE_IN <= DEPTH_C);
    assign last_s         = ({{(CONTROL_SIZE-ADDR_SIZE){1'b0}}, index_r} == (size_r - CONTROL_SIZE'(1'b1)));
    assign wdog_inc_s     = wdog_r + WDOG_W'(1'b1);
    assign wdog_expired_s = (wdog_r >= WDOG_LAST_C);
    assign load_we_s      = LOAD_ENABLE && (state_r == ST_IDLE);

    // Next-state and next-output decode; outputs are registered from these values
    always_comb begin
        state_nx_s  = state_r;
        index_nx_s  = index_r;
        size_nx_s   = size_r;
        wdog_nx_s   = wdog_r;
        ready_nx_s  = 1'b0;
        error_nx_s  = 1'b0;
        vstart_nx_s = 1'b0;
        strobe_nx_s = 1'b0;
        res_we_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (START && size_ok_s) begin
                    size_nx_s   = SIZE_IN;
                    index_nx_s  = {ADDR_SIZE{1'b0}};
                    vstart_nx_s = 1'b1;
                    state_nx_s  = ST_LAUNCH;
                end else if (START) begin
                    // Bad size: report immediately, vector interface untouched
                    ready_nx_s = 1'b1;
                    error_nx_s = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                strobe_nx_s = 1'b1;
                state_nx_s  = ST_SEND;
            end
            ST_SEND: begin
                wdog_nx_s  = {WDOG_W{1'b0}};
                state_nx_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (DATA_IN_ENABLE) begin
                    res_we_s = 1'b1;
                    if (!last_s) begin
                        index_nx_s  = index_r + ADDR_SIZE'(1'b1);
                        strobe_nx_s = 1'b1;
                        state_nx_s  = ST_SEND;
                    end else if (VECTOR_READY) begin
                        ready_nx_s = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else begin
                        wdog_nx_s  = wdog_inc_s;
                        state_nx_s = ST_DONE;
                    end
                end else if (wdog_expired_s) begin
                    ready_nx_s = 1'b1;
                    error_nx_s = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    wdog_nx_s = wdog_inc_s;
                end
            end
            ST_DONE: begin
                if (VECTOR_READY) begin
                    ready_nx_s = 1'b1;
                    state_nx_s = ST_IDLE;
                end else if (wdog_expired_s) begin
                    ready_nx_s = 1'b1;
                    error_nx_s = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    wdog_nx_s = wdog_inc_s;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, run bookkeeping and all registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r       <= ST_IDLE;
            index_r       <= {ADDR_SIZE{1'b0}};
            size_r        <= {CONTROL_SIZE{1'b0}};
            wdog_r        <= {WDOG_W{1'b0}};
            ready_r       <= 1'b0;
            error_r       <= 1'b0;
            vstart_r      <= 1'b0;
            strobe_r      <= 1'b0;
            size_out_r    <= {CONTROL_SIZE{1'b0}};
            a_out_r       <= {DATA_SIZE{1'b0}};
            b_out_r       <= {DATA_SIZE{1'b0}};
            result_data_r <= {DATA_SIZE{1'b0}};
        end else begin
            state_r  <= state_nx_s;
            index_r  <= index_nx_s;
            size_r   <= size_nx_s;
            wdog_r   <= wdog_nx_s;
            ready_r  <= ready_nx_s;
            error_r  <= error_nx_s;
            vstart_r <= vstart_nx_s;
            strobe_r <= strobe_nx_s;
            if (vstart_nx_s) begin
                size_out_r <= size_nx_s;
            end
            // Operands are fetched with the index the SEND state will use
            if (strobe_nx_s) begin
                a_out_r <= buf_a_r[index_nx_s];
                b_out_r <= buf_b_r[index_nx_s];
            end
            result_data_r <= res_buf_r[RESULT_ADDRESS];
        end
    end

    // Host operand writes (IDLE only) and result capture during WAIT
    always_ff @(posedge CLK) begin
        if (load_we_s && !LOAD_SELECT) begin
            buf_a_r[LOAD_ADDRESS] <= LOAD_DATA;
        end
        if (load_we_s && LOAD_SELECT) begin
            buf_b_r[LOAD_ADDRESS] <= LOAD_DATA;
        end
        if (res_we_s) begin
            res_buf_r[index_r] <= DATA_IN;
        end
    end

    assign READY             = ready_r;
    assign ERROR             = error_r;
    assign VECTOR_START      = vstart_r;
    assign SIZE_OUT          = size_out_r;
    assign DATA_A_OUT_ENABLE = strobe_r;
    assign DATA_B_OUT_ENABLE = strobe_r;
    assign DATA_A_OUT        = a_out_r;
    assign DATA_B_OUT        = b_out_r;
    assign RESULT_DATA       = result_data_r;

endmodule

// File: doc/accelerator_vector_integer_stream_driver.md
# accelerator_vector_integer_stream_driver

Initiator-side sequencer for the vector integer accelerators. It holds two operand vectors in local buffers loaded by the host. On START it launches a vector unit, then streams element pairs over the DATA_A/DATA_B enable-strobe interface, one pair per result. It captures each returned element into a result buffer the host can read back.

## Interface
- DATA_SIZE, 64, element width
- CONTROL_SIZE, 64, width of size/index values
- ADDR_SIZE, 4, buffer address width; DEPTH = 2**ADDR_SIZE elements per buffer
- TIMEOUT, 1024, max cycles spent waiting on the vector unit before abort
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, asynchronous, active-low (0 = reset)
- START  in  1  begin a run (sampled in IDLE only)
- READY  out  1  one-cycle pulse when a run ends (success or error)
- ERROR  out  1  one-cycle pulse coincident with READY on error
- SIZE_IN  in  CONTROL_SIZE  element count for the run
- LOAD_ENABLE  in  1  host write strobe into operand buffers
- LOAD_SELECT  in  1  0 = buffer A, 1 = buffer B
- LOAD_ADDRESS  in  ADDR_SIZE  host write address
- LOAD_DATA  in  DATA_SIZE  host write data
- RESULT_ADDRESS  in  ADDR_SIZE  host read address
- RESULT_DATA  out  DATA_SIZE  result buffer contents, registered
- VECTOR_START  out  1  start pulse to vector unit
- VECTOR_READY  in  1  vector unit done
- SIZE_OUT  out  CONTROL_SIZE  element count to vector unit
- DATA_A_OUT_ENABLE, DATA_B_OUT_ENABLE  out  1  operand strobes
- DATA_A_OUT, DATA_B_OUT  out  DATA_SIZE  operand elements
- DATA_IN_ENABLE  in  1  result strobe from vector unit
- DATA_IN  in  DATA_SIZE  result element

## Operation
- States: IDLE, LAUNCH, SEND, WAIT, DONE. Reset state is IDLE.
- IDLE:
  - LOAD_ENABLE writes LOAD_DATA into the buffer given by LOAD_SELECT at LOAD_ADDRESS. Writes in any other state are ignored.
  - START with 1 <= SIZE_IN <= DEPTH: latch size, set index=0, go to LAUNCH.
  - START with SIZE_IN=0 or SIZE_IN>DEPTH: pulse READY and ERROR next cycle, stay in IDLE, do not touch the vector interface.
- LAUNCH: VECTOR_START=1 for one cycle; SIZE_OUT=latched size and held until the next run. Go to SEND.
- SEND: DATA_A_OUT=A[index], DATA_B_OUT=B[index], both enables =1 for exactly one cycle. Clear the watchdog. Go to WAIT.
- WAIT: on DATA_IN_ENABLE, write result[index]=DATA_IN.
  - If index != size-1: index+1, go to SEND.
  - If last element and VECTOR_READY=1 in the same cycle: pulse READY, go to IDLE.
  - If last element without VECTOR_READY: go to DONE.
- DONE: on VECTOR_READY, pulse READY and go to IDLE.
- Watchdog: counts cycles in WAIT/DONE. Reaching TIMEOUT pulses READY and ERROR, goes to IDLE, and leaves result entries already captured intact.
- DATA_IN_ENABLE outside WAIT is ignored. START outside IDLE is ignored.
- Operand and result buffers are not reset; contents are undefined after reset.

## Timing
- Reset values: READY, ERROR, VECTOR_START, both OUT_ENABLEs = 0; DATA_A_OUT, DATA_B_OUT, SIZE_OUT, RESULT_DATA = 0; index and watchdog = 0.
- Reset mid-run: immediate return to IDLE with all strobes low; no READY pulse.
- All outputs are registered.
- START sampled at edge 0 gives VECTOR_START at cycle 1 and the first operand strobes at cycle 2.
- Minimum element period is 2 cycles (SEND + one WAIT cycle). Next operand strobes follow DATA_IN_ENABLE by exactly 1 cycle.
- READY follows the final DATA_IN_ENABLE, or the VECTOR_READY that closes the run, by 1 cycle.
- RESULT_DATA = result[RESULT_ADDRESS] one cycle after the address is applied. A result written in the same cycle is visible one cycle later, i.e. write-first is not required.
- Simultaneous LOAD_ENABLE and START in IDLE: the write completes, and the run uses the updated data.

## Test plan
- Load A=[2,3,4], B=[5,6,7]; SIZE_IN=3; model returns A*B two cycles after each strobe, with VECTOR_READY on the last -> results [10,18,28], READY high cycle 1 after third DATA_IN_ENABLE, ERROR=0, three strobe pairs total.
- SIZE_IN=0, then SIZE_IN=DEPTH+1 -> READY and ERROR pulse together the cycle after each START; VECTOR_START never asserted.
- SIZE_IN=DEPTH=16 with zero-latency model (DATA_IN_ENABLE the cycle after strobe) -> strobes every 2 cycles, all 16 results correct, index wraps cleanly to IDLE.
- Model never answers the second element -> READY+ERROR exactly TIMEOUT cycles after entering WAIT; result[0] retained, result[1] unchanged.
- VECTOR_READY delayed 5 cycles after last result -> FSM sits in DONE, READY pulses 1 cycle after VECTOR_READY.
- Assert RST low during WAIT of element 1, release, run SIZE_IN=1 with A=[9], B=[9] -> all outputs 0 during reset, new run returns result 81 normally.
